// File: rtl/top.sv
// Radix-2 MSDF online serial-serial adder, borrow-save digits.
// One N-digit addition per reset release; emits N+2 sum digits.
module top #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] xj_plus_3,
  input  logic [1:0] yj_plus_3,
  output logic [1:0] Zj,
  output logic       ready_Zj
);

  localparam logic [1:0] R2_ZERO    = 2'b00;
  localparam logic [1:0] R2_POS_ONE = 2'b10;
  localparam logic [1:0] R2_NEG_ONE = 2'b01;

  localparam int CW = $clog2(N + 3);
  localparam logic [CW-1:0] LAST = CW'(N + 2);

  logic signed [2:0] r_w;
  logic [CW-1:0]     r_cnt;

  logic signed [2:0] w_xd;
  logic signed [2:0] w_yd;
  logic signed [2:0] w_s;
  logic signed [3:0] w_v;
  logic signed [3:0] w_vn;
  logic [1:0]        w_zc;
  logic              w_act;

  // p - n; code 11 cancels to zero
  function automatic logic signed [2:0] dec(
    input logic [1:0] d
  );
    logic signed [2:0] v;
    v = 3'sd0;
    if (d[1] && !d[0]) v = 3'sd1;
    if (d[0] && !d[1]) v = -3'sd1;
    return v;
  endfunction

  assign w_xd  = dec(xj_plus_3);
  assign w_yd  = dec(yj_plus_3);
  assign w_s   = w_xd + w_yd;
  assign w_v   = $signed({r_w, 1'b0})
               + $signed({w_s[2], w_s});
  assign w_act = (r_cnt != LAST);

  always_comb begin
    w_zc = R2_ZERO;
    w_vn = w_v;
    unique case (1'b1)
      (w_v >= 4'sd2): begin
        w_zc = R2_POS_ONE;
        w_vn = w_v - 4'sd4;
      end
      (w_v <= -4'sd2): begin
        w_zc = R2_NEG_ONE;
        w_vn = w_v + 4'sd4;
      end
      default: begin
        w_zc = R2_ZERO;
        w_vn = w_v;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w      <= 3'sd0;
      r_cnt    <= '0;
      Zj       <= R2_ZERO;
      ready_Zj <= 1'b0;
    end else if (w_act) begin
      r_w      <= w_vn[2:0];
      r_cnt    <= r_cnt + 1'b1;
      Zj       <= w_zc;
      ready_Zj <= 1'b1;
    end else begin
      Zj       <= R2_ZERO;
      ready_Zj <= 1'b0;
    end
  end

endmodule

// File: tb/tb_top.sv
// Randomised and directed bench for the online adder.
// Reference model works on plain integer digits and sum values.
module tb_top;

  localparam int N = 8;

  logic       clk;
  logic       rst;
  logic [1:0] xj_plus_3;
  logic [1:0] yj_plus_3;
  logic [1:0] Zj;
  logic       ready_Zj;

  int n_chk;
  int n_fail;
  int obs_z[N+2];

  top #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .xj_plus_3(xj_plus_3),
    .yj_plus_3(yj_plus_3),
    .Zj       (Zj),
    .ready_Zj (ready_Zj)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, int obs, int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] enc(int d, bit alt0);
    if (d > 0) return 2'b10;
    if (d < 0) return 2'b01;
    return alt0 ? 2'b11 : 2'b00;
  endfunction

  function automatic int dv(logic [1:0] d);
    return int'(d[1]) - int'(d[0]);
  endfunction

  // Online addition by the digit rules, in units of 1/4
  function automatic void model(
    input  int xs[N],
    input  int ys[N],
    output int zs[N+2]
  );
    int w, v, s;
    w = 0;
    for (int t = 0; t < N + 2; t++) begin
      s = (t < N) ? xs[t] + ys[t] : 0;
      v = 2 * w + s;
      zs[t] = (v >= 2) ? 1 : (v <= -2) ? -1 : 0;
      w = v - 4 * zs[t];
    end
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      xj_plus_3 = 2'($urandom);
      yj_plus_3 = 2'($urandom);
      @(posedge clk);
      #1;
      check("rst_z", int'(Zj), 0);
      check("rst_rdy", int'(ready_Zj), 0);
    end
    rst = 1'b1;
  endtask

  task automatic run_op(
    string tag,
    input int xs[N],
    input int ys[N],
    input int abort_at,
    input int mode11
  );
    int ez[N+2];
    int sv, zv;
    model(xs, ys, ez);
    for (int t = 1; t <= N + 2; t++) begin
      bit a;
      a = (mode11 == 2) ? 1'b1 : (mode11 == 1) ? 1'($urandom) : 1'b0;
      xj_plus_3 = (t <= N) ? enc(xs[t-1], a) : enc(0, a);
      yj_plus_3 = (t <= N) ? enc(ys[t-1], a) : enc(0, a);
      @(posedge clk);
      #1;
      obs_z[t-1] = dv(Zj);
      check({tag, "_z"}, int'(Zj), int'(enc(ez[t-1], 1'b0)));
      check({tag, "_rdy"}, int'(ready_Zj), 1);
      if (t == abort_at) begin
        #3 rst = 1'b0;
        #1;
        check({tag, "_abort_z"}, int'(Zj), 0);
        check({tag, "_abort_rdy"}, int'(ready_Zj), 0);
        return;
      end
    end
    for (int i = 0; i < 3; i++) begin
      xj_plus_3 = 2'($urandom);
      yj_plus_3 = 2'($urandom);
      @(posedge clk);
      #1;
      check({tag, "_done_z"}, int'(Zj), 0);
      check({tag, "_done_rdy"}, int'(ready_Zj), 0);
    end
    sv = 0;
    zv = 0;
    for (int i = 1; i <= N; i++)
      sv += (xs[i-1] + ys[i-1]) * (1 << (N - i));
    for (int t = 1; t <= N + 2; t++)
      zv += obs_z[t-1] * (1 << (N + 2 - t));
    check({tag, "_value"}, zv, sv);
  endtask

  initial begin
    int mx[N] = '{0, 1, 0, -1, 1, 1, 0, -1};
    int my[N] = '{1, 0, -1, 0, 1, -1, -1, 0};
    int mz[N+2] = '{0, 1, -1, 0, 1, 0, 0, -1, 1, -1};
    int pz[N+2] = '{1, -1, 1, 1, 1, 1, 1, 1, 1, 0};
    int p1[N] = '{default: 1};
    int n1[N] = '{default: -1};
    int z0[N] = '{default: 0};
    int rx[N];
    int ry[N];
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    xj_plus_3 = 2'b00;
    yj_plus_3 = 2'b00;
    #2;
    check("init_z", int'(Zj), 0);
    check("init_rdy", int'(ready_Zj), 0);

    do_reset();
    run_op("mix", mx, my, 0, 0);
    for (int t = 0; t < N + 2; t++)
      check("mix_tab", obs_z[t], mz[t]);

    do_reset();
    run_op("maxp", p1, p1, 0, 0);
    for (int t = 0; t < N + 2; t++)
      check("maxp_tab", obs_z[t], pz[t]);

    do_reset();
    run_op("maxn", n1, n1, 0, 0);
    for (int t = 0; t < N + 2; t++)
      check("maxn_tab", obs_z[t], -pz[t]);

    do_reset();
    run_op("cancel", p1, n1, 0, 0);
    do_reset();
    run_op("code11", z0, z0, 0, 2);

    do_reset();
    run_op("abort", mx, my, 5, 0);
    do_reset();
    run_op("rerun", mx, my, 0, 0);
    for (int t = 0; t < N + 2; t++)
      check("rerun_tab", obs_z[t], mz[t]);

    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < N; i++) begin
        rx[i] = int'($urandom_range(0, 2)) - 1;
        ry[i] = int'($urandom_range(0, 2)) - 1;
      end
      do_reset();
      run_op("rand", rx, ry, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/top.md
Name: top

Overview:
- Radix-2 most-significant-digit-first (MSDF) online serial-serial adder.
- Accepts one signed digit of each operand per clock, MSD first, and emits one signed sum digit per clock, MSD first.
- Digits use the codebase's borrow-save radix-2 encoding (Bit_rep.vh constants).
- Operates as a standalone datapath leaf: one N-digit addition per reset release.

Parameters:
- N, 8, number of fractional digits per operand (x = sum of x_i*2^-i, i = 1..N).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- xj_plus_3  input  2  current digit of operand x, borrow-save encoded.
- yj_plus_3  input  2  current digit of operand y, same encoding.
- Zj  output  2  current sum digit, same encoding; registered.
- ready_Zj  output  1  high while Zj carries a valid sum digit; registered.

Behaviour:
- Digit encoding: bit[1] = positive flag, bit[0] = negative flag, value = p - n.
  - R2_ZERO = 2'b00, R2_POS_ONE = 2'b10, R2_NEG_ONE = 2'b01.
  - Input 2'b11 is accepted and means 0.
  - Zj only ever takes the values 00, 10 or 01.
- Reset (rst = 0, asynchronous): residual W = 0, step counter = 0, Zj = 2'b00, ready_Zj = 0. Held for as long as rst is low.
- Step t = 1 is the first rising edge with rst = 1. At step t the block samples x_t and y_t.
- Digits x_t and y_t for t > N must be driven as zero by the source; the block does not force them.
- Recurrence, executed once per step t = 1..N+2, in integers scaled by 4:
  - s = x_t + y_t, range [-2, 2].
  - V = 2*W + s, range [-6, 6], 4-bit signed.
  - Digit select: z = +1 if V >= 2; z = -1 if V <= -2; z = 0 otherwise.
  - Residual update: W <= V - 4*z, range [-2, 2], 3-bit signed.
- Output register: at step t, Zj <= encode(z) and ready_Zj <= 1.
- Result: z_t has weight 2^(2-t), so outputs carry weights 2^1 down to 2^-N (N+2 digits). The sum x + y is exact; the final residual is 0.
- Latency: z_t is visible from step t until step t+1. The first valid digit appears one clock after the first sample. Online delay is 2 in digit weight.
- Step counter: saturates after step N+2, width clog2(N+3).
- Completion: at step N+3 and every later edge, Zj <= 00, ready_Zj <= 0 and W holds. All later inputs are ignored until the next reset.
- No input handshake: every edge while active consumes a digit pair.
- Reset mid-operation: aborts immediately. A fresh addition starts at the first edge after rst returns high.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with arbitrary inputs -> Zj = 00 and ready_Zj = 0 throughout; outputs clear asynchronously when rst falls mid-cycle.
- Mixed operands, N = 8:
  - x = 0,+1,0,-1,+1,+1,0,-1 and y = +1,0,-1,0,+1,-1,-1,0, then two zero pairs.
  - Required z = 0,+1,-1,0,+1,0,0,-1,+1,-1 (value 0.61328125).
  - ready_Zj high exactly 10 cycles, then low with Zj = 00.
- Maximum positive: all x = y = +1, then zeros -> z = +1,-1,+1,+1,+1,+1,+1,+1,+1,0 (value 1.9921875).
- Maximum negative: all x = y = -1 -> digit-wise negation of the previous sequence; also x = +1s with y = -1s -> all z = 0.
- Code 11: drive 2'b11 on both inputs for all 8 digits -> all z = 0, identical to driving 2'b00.
- Abort and restart: assert rst at step 5 of the mixed-operands case, release, then rerun it -> the full correct 10-digit sequence with no carried-over residual; inputs after step 10 have no effect.
